adder_result_accumulator: RTL and testbench
===========================================

# adder_result_accumulator

Downstream consumer of the adder stage: captures each `{carry, sum}` result through a valid/ready handshake and accumulates `COUNT` consecutive results into a widened, overflow-free total. The finished total is presented with a valid/ready output handshake for the next stage. A `flush` input closes a partial accumulation early. Results are zero-extended, so each one is treated as an unsigned `BITS+1`-bit value.

## Interface

- `BITS`, 8: width of the adder `sum` result.
- `COUNT`, 4: results per accumulation. Legal range is 2 or more.
- `ACC_W`, derived localparam = `BITS+1+$clog2(COUNT)`: accumulator width. Must not be overridden.
- `CNT_W`, derived localparam = `$clog2(COUNT+1)`: beat-count width.

Ports:

- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `in_valid`, input, 1: the `carry`/`sum` pair is valid.
- `in_ready`, output, 1: block accepts a result this cycle.
- `carry`, input, 1: adder carry-out, used as bit `BITS` of the beat value.
- `sum`, input, `BITS`: adder sum, used as bits `BITS-1:0` of the beat value.
- `flush`, input, 1: close the current accumulation after this cycle's beat, if any.
- `out_valid`, output, 1: `out_acc` and `out_beats` hold a finished total.
- `out_ready`, input, 1: downstream accepts the total.
- `out_acc`, output, `ACC_W`: accumulated total.
- `out_beats`, output, `CNT_W`: number of results in `out_acc`, from 1 to `COUNT`.

## Operation

- Two states: `ACCUM` (reset state) and `OUTPUT`.
- `in_ready` = (state == `ACCUM`). It is combinational from the state only, with no dependence on `in_valid` or `out_ready`.
- Accept = `in_valid && in_ready`. Beat value = zero-extend(`{carry, sum}`) to `ACC_W`.
- In `ACCUM` on accept with `cnt+1 < COUNT` and `flush == 0`:
  - `acc <= acc + beat`;
  - `cnt <= cnt + 1`.
- In `ACCUM`, move to `OUTPUT` on either of these conditions:
  - accept with `cnt+1 == COUNT`;
  - `flush == 1` with an accept, or with `cnt > 0`.
- On the move to `OUTPUT`:
  - `out_acc <= acc + (accept ? beat : 0)`;
  - `out_beats <= cnt + accept`;
  - internal `acc` and `cnt` clear to 0.
- `flush` in `ACCUM` with `cnt == 0` and no accept: ignored, no output.
- In `OUTPUT`:
  - `out_valid = 1`;
  - `out_acc` and `out_beats` are held stable until `out_ready`;
  - inputs are not accepted;
  - `flush` is ignored.
- `out_valid && out_ready`: return to `ACCUM` next cycle.
- Arithmetic is unsigned. `COUNT * (2^(BITS+1) - 1)` always fits in `ACC_W`, so no truncation or overflow is possible.
- `carry`, `sum` and `flush` are don't-care when `in_valid == 0`, except that `flush` still acts when `cnt > 0`.

## Timing

- Reset values: state = `ACCUM`, `acc` = 0, `cnt` = 0, `out_acc` = 0, `out_beats` = 0, `out_valid` = 0, `in_ready` = 1.
- Reset asserted mid-accumulation or in `OUTPUT` discards the partial total or the pending output immediately.
- The first accept is possible in the first cycle after reset deasserts.
- Latency: the beat that completes an accumulation at edge N gives `out_valid = 1` after edge N, i.e. one cycle.
- The earliest next accept is the cycle after the output handshake. Maximum throughput is therefore `COUNT` results per `COUNT+1` cycles when `out_ready` is held high.
- `out_ready` high while `out_valid` is low has no effect.
- `out_valid` never drops without a handshake, except on reset.
- Upstream holding `in_valid` high while `in_ready` is low must not lose or duplicate a beat. The beat is accepted on the first `ACCUM` cycle.

## Test plan

All scenarios use `BITS=8`, `COUNT=4`, so `ACC_W=11` and `CNT_W=3`.

- **Basic accumulation.** Beats `{0,0xFF}`, `{1,0xFF}`, `{1,0x00}`, `{0,0x01}` back-to-back with `out_ready=1` -> `out_valid` one cycle after the 4th accept, `out_acc=0x3FF`, `out_beats=4`, `in_ready=0` for exactly that cycle.
- **Maximum value.** Four beats of `{1,0xFF}` -> `out_acc=0x7FC` with no wrap. The next four beats of `{0,0x02}` -> `out_acc=0x008`, proving `acc` cleared.
- **Flush.** Two beats of `0x10`, then `flush=1` with no beat -> `out_acc=0x020`, `out_beats=2`. Next, `flush=1` together with a beat `0x05` at `cnt=0` -> `out_acc=0x005`, `out_beats=1`. Next, `flush=1` alone at `cnt=0` -> no `out_valid`.
- **Backpressure.** Complete an accumulation with `out_ready=0` for 5 cycles while upstream holds `in_valid=1` with beat `0x07` -> outputs stable, `in_ready=0` throughout. After `out_ready` pulses, beat `0x07` is accepted exactly once.
- **Reset mid-operation.** Assert `reset` after 3 beats, then separately while `out_valid=1` -> all outputs go to reset values asynchronously. The following 4 beats of `0x01` give `out_acc=0x004`.

Source files
------------

// File: rtl/adder_result_accumulator.sv
// Collects COUNT adder results ({carry, sum}) into a widened unsigned total and
// hands the total downstream; flush closes a partial accumulation early.
module adder_result_accumulator #(
  parameter int BITS  = 8,
  parameter int COUNT = 4,
  localparam int ACC_W = BITS + 1 + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             carry,
  input  logic [BITS-1:0]  sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_beats,
  output logic             debug_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready depends on state only; out_valid holds until taken.
  typedef enum logic {S_ACCUM = 1'b0, S_OUTPUT = 1'b1} state_t;

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] beat;
  logic [ACC_W-1:0] beat_or_zero;
  logic [CNT_W-1:0] cnt_plus_one;
  logic [CNT_W-1:0] accept_ext;
  logic             accept;
  logic             last_beat;
  logic             close;

  assign accept       = in_valid && in_ready;
  assign beat         = {{(ACC_W-BITS-1){1'b0}}, carry, sum};
  assign beat_or_zero = accept ? beat : '0;
  assign cnt_plus_one = cnt + CNT_W'(1);
  assign accept_ext   = {{(CNT_W-1){1'b0}}, accept};
  assign last_beat    = accept && (cnt_plus_one == CNT_W'(COUNT));
  // A lone flush with nothing collected produces no output.
  assign close        = (state == S_ACCUM) &&
                        (last_beat || (flush && (accept || (cnt != '0))));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_ACCUM:  if (close)     state_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_next = S_ACCUM;
      default:                 state_next = S_ACCUM;
    endcase
  end

  always_comb begin
    in_ready    = (state == S_ACCUM);
    out_valid   = (state == S_OUTPUT);
    debug_state = state;
  end

  // out_acc/out_beats only load on close, so they stay stable while in OUTPUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_acc   <= '0;
      out_beats <= '0;
    end else if (close) begin
      out_acc   <= acc + beat_or_zero;
      out_beats <= cnt + accept_ext;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      acc <= acc + beat;
      cnt <= cnt_plus_one;
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator with BITS=8, COUNT=4
// (ACC_W=11, CNT_W=3); expected values are hand-computed constants.
module tb_adder_result_accumulator;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        carry;
  logic [7:0]  sum;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_acc;
  logic [2:0]  out_beats;
  logic        debug_state;

  int vectors;
  int miscompares;

  adder_result_accumulator #(.BITS(8), .COUNT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .carry       (carry),
    .sum         (sum),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_beats   (out_beats),
    .debug_state (debug_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks: inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_beat(input logic c, input logic [7:0] s, input logic f);
    in_valid = 1'b1;
    carry    = c;
    sum      = s;
    flush    = f;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    carry    = 1'b0;
    sum      = 8'h00;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++;
    if (out_acc !== 11'h000) begin miscompares++; $display("FAIL reset_out_acc got %h exp 000", out_acc); end
    vectors++;
    if (out_beats !== 3'd0) begin miscompares++; $display("FAIL reset_out_beats got %0d exp 0", out_beats); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(1'b0, 8'hFF, 1'b0);
    drive_beat(1'b1, 8'hFF, 1'b0);
    drive_beat(1'b1, 8'h00, 1'b0);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_mid got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    drive_beat(1'b0, 8'h01, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    vectors++;
    if (out_acc !== 11'h3FF) begin miscompares++; $display("FAIL basic_out_acc got %h exp 3ff", out_acc); end
    vectors++;
    if (out_beats !== 3'd4) begin miscompares++; $display("FAIL basic_out_beats got %0d exp 4", out_beats); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_low got %b exp 0", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL basic_after_hs got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max_value();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 8'hFF, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h7FC) begin
      miscompares++; $display("FAIL max_acc got valid=%b acc=%h exp 1 7fc", out_valid, out_acc);
    end
    tick();
    for (int i = 0; i < 4; i++) drive_beat(1'b0, 8'h02, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h008) begin
      miscompares++; $display("FAIL max_cleared got valid=%b acc=%h exp 1 008", out_valid, out_acc);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive_beat(1'b0, 8'h10, 1'b0);
    drive_beat(1'b0, 8'h10, 1'b0);
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h020 || out_beats !== 3'd2) begin
      miscompares++;
      $display("FAIL flush_partial got valid=%b acc=%h beats=%0d exp 1 020 2", out_valid, out_acc, out_beats);
    end
    tick();
    drive_beat(1'b0, 8'h05, 1'b1);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h005 || out_beats !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_with_beat got valid=%b acc=%h beats=%0d exp 1 005 1", out_valid, out_acc, out_beats);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_empty got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(1'b0, 8'h07, 1'b0);
    // upstream keeps offering 0x07 while the total waits
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_acc !== 11'h01C || out_beats !== 3'd4 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got valid=%b acc=%h beats=%0d in_ready=%b exp 1 01c 4 0",
                 i, out_valid, out_acc, out_beats, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release got valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
    end
    tick();
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 8'h01, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h00A || out_beats !== 3'd4) begin
      miscompares++;
      $display("FAIL bp_once got valid=%b acc=%h beats=%0d exp 1 00a 4", out_valid, out_acc, out_beats);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 8'h01, 1'b0);
    idle();
    reset = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 11'h000 || out_beats !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_partial got valid=%b in_ready=%b acc=%h beats=%0d exp 0 1 000 0",
               out_valid, in_ready, out_acc, out_beats);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 8'h80, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h600) begin
      miscompares++; $display("FAIL rst_fill got valid=%b acc=%h exp 1 600", out_valid, out_acc);
    end
    reset = 1'b1;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 11'h000 || out_beats !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_output got valid=%b in_ready=%b acc=%h beats=%0d exp 0 1 000 0",
               out_valid, in_ready, out_acc, out_beats);
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) drive_beat(1'b0, 8'h01, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_acc !== 11'h004 || out_beats !== 3'd4) begin
      miscompares++;
      $display("FAIL rst_after got valid=%b acc=%h beats=%0d exp 1 004 4", out_valid, out_acc, out_beats);
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_max_value();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
